// File: rtl/iterative_divider_32_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
// Latency: none, wires only.
// Backpressure: the requester must hold off start while busy is high.
interface iterative_divider_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // Requester side: issues operations and collects results.
    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    // Divider side.
    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/iterative_divider_32.sv
// Restoring radix-2 divider implementing DIV/DIVU/REM/REMU, one op in flight.
// Latency: done WIDTH+2 cycles after start is accepted, for every operand value.
// Backpressure: start is only accepted while busy is low; start during busy is dropped.
module iterative_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    iterative_divider_32_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;        // original dividend, needed for REM by zero
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;  // |divisor| for the unsigned core
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;    // starts as |dividend|, shifts out as quotient fills in
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] fix_val;

    // op[0]=0 marks the signed flavours (DIV, REM); op[1]=1 selects the remainder.
    assign signed_op = ~op_q[0];
    assign a_abs     = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_abs     = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;

    // Trial subtraction in WIDTH+1 bits. A set top bit in the shifted remainder
    // already guarantees it exceeds any WIDTH-bit divisor, so no borrow then.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvsr_q};
    assign borrow = ~rem_sh[WIDTH] & trial[WIDTH];

    // Final result with the special cases taking priority over sign fix-up.
    always_comb begin
        fix_val = '0;
        if (div0_q) begin
            fix_val = op_q[1] ? a_q : '1;
        end else if (ovf_q) begin
            fix_val = op_q[1] ? '0 : INT_MIN;
        end else if (op_q[1]) begin
            fix_val = rneg_q ? -rem_q : rem_q;
        end else begin
            fix_val = qneg_q ? -quo_q : quo_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = PREP;
            PREP:    state_d = ITER;
            ITER:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: done and the fresh result are presented during FIX itself.
    always_comb begin
        bus.busy   = (state_q != IDLE);
        bus.done   = (state_q == FIX);
        bus.result = (state_q == FIX) ? fix_val : result_q;
    end

    // Datapath next-state: capture, prepare magnitudes, iterate, latch result.
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d = bus.op;
                    a_d  = bus.a;
                    b_d  = bus.b;
                end
            end
            PREP: begin
                qneg_d = signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d = signed_op & a_q[WIDTH-1];
                quo_d  = a_abs;
                dvsr_d = b_abs;
                div0_d = (b_q == '0);
                ovf_d  = signed_op && (a_q == INT_MIN) && (b_q == '1);
                rem_d  = '0;
                cnt_d  = CNT_INIT;
            end
            ITER: begin
                rem_d = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                result_d = fix_val;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end
endmodule
